// File: rtl/serial_divisibility_by_n.sv
// rtl/serial_divisibility_by_n.sv - serial mod-N checker, optional LSB-first mode via SERIAL_DIV_LSB_FIRST_EN
module serial_divisibility_by_n #(
    parameter int DIVISOR = 5,
    parameter int CNT_W   = 8,
    localparam int RW     = $clog2(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_bit_vld,
    input  logic             new_bit,
    input  logic             new_bit_first,
    output logic             div_vld,
    output logic             div_by_n,
    output logic [RW-1:0]    remainder,
    output logic [CNT_W-1:0] bit_count
);

    generate
        if (DIVISOR < 2 || DIVISOR > 255) begin : g_bad_divisor
            $error("serial_divisibility_by_n: DIVISOR must be within 2..255");
        end
    endgenerate

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [RW:0]      N_W   = (RW + 1)'(DIVISOR);
    localparam logic [CNT_W-1:0] C_MAX = '1;

    state_t           st, st_next;
    logic [RW-1:0]    r_q, r_next, r0;
    logic [CNT_W-1:0] c_q, c_next, c0;
    logic             vld_next;
    logic             fresh;

`ifdef SERIAL_DIV_LSB_FIRST_EN
    logic [RW-1:0] w_q, w_next, w0;
    logic [RW:0]   s_sum, w_dbl;
`else
    logic [RW:0]   t_sum;
`endif

    // A marked first bit or the first bit after reset restarts the number from zero.
    assign fresh = new_bit_first || (st == IDLE);
    assign r0    = fresh ? '0 : r_q;
    assign c0    = fresh ? '0 : c_q;
`ifdef SERIAL_DIV_LSB_FIRST_EN
    assign w0    = fresh ? RW'(1) : w_q;
`endif

    always_comb begin
        st_next  = st;
        r_next   = r_q;
        c_next   = c_q;
        vld_next = 1'b0;
`ifdef SERIAL_DIV_LSB_FIRST_EN
        w_next   = w_q;
        s_sum    = {1'b0, r0} + (new_bit ? {1'b0, w0} : '0);
        w_dbl    = {w0, 1'b0};
`else
        t_sum    = {r0, new_bit};
`endif
        if (new_bit_vld) begin
            st_next  = ACTIVE;
            vld_next = 1'b1;
            c_next   = (c0 == C_MAX) ? c0 : c0 + 1'b1;
`ifdef SERIAL_DIV_LSB_FIRST_EN
            // Both sums stay below 2N, so one conditional subtract reduces them.
            r_next = (s_sum >= N_W) ? RW'(s_sum - N_W) : RW'(s_sum);
            w_next = (w_dbl >= N_W) ? RW'(w_dbl - N_W) : RW'(w_dbl);
`else
            r_next = (t_sum >= N_W) ? RW'(t_sum - N_W) : RW'(t_sum);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= IDLE;
            r_q      <= '0;
            c_q      <= '0;
            div_vld  <= 1'b0;
            div_by_n <= 1'b1;
`ifdef SERIAL_DIV_LSB_FIRST_EN
            w_q      <= RW'(1);
`endif
        end else begin
            st       <= st_next;
            r_q      <= r_next;
            c_q      <= c_next;
            div_vld  <= vld_next;
            div_by_n <= (r_next == '0);
`ifdef SERIAL_DIV_LSB_FIRST_EN
            w_q      <= w_next;
`endif
        end
    end

    assign remainder = r_q;
    assign bit_count = c_q;

endmodule

// File: tb/tb_serial_divisibility_by_n.sv
// tb/tb_serial_divisibility_by_n.sv - randomized and directed checks of three divisor configurations
module tb_serial_divisibility_by_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic new_bit_vld = 1'b0;
    logic new_bit = 1'b0;
    logic new_bit_first = 1'b0;

    logic       vld5, vld7, vld2, dbn5, dbn7, dbn2;
    logic [2:0] rem5, rem7;
    logic [0:0] rem2;
    logic [7:0] cnt5, cnt7;
    logic [2:0] cnt2;

    always #5 clk = ~clk;

    serial_divisibility_by_n #(.DIVISOR(5), .CNT_W(8)) u5 (
        .clk(clk), .rst(rst), .new_bit_vld(new_bit_vld), .new_bit(new_bit),
        .new_bit_first(new_bit_first), .div_vld(vld5), .div_by_n(dbn5),
        .remainder(rem5), .bit_count(cnt5));
    serial_divisibility_by_n #(.DIVISOR(7), .CNT_W(8)) u7 (
        .clk(clk), .rst(rst), .new_bit_vld(new_bit_vld), .new_bit(new_bit),
        .new_bit_first(new_bit_first), .div_vld(vld7), .div_by_n(dbn7),
        .remainder(rem7), .bit_count(cnt7));
    serial_divisibility_by_n #(.DIVISOR(2), .CNT_W(3)) u2 (
        .clk(clk), .rst(rst), .new_bit_vld(new_bit_vld), .new_bit(new_bit),
        .new_bit_first(new_bit_first), .div_vld(vld2), .div_by_n(dbn2),
        .remainder(rem2), .bit_count(cnt2));

    int ns[3]  = '{5, 7, 2};
    int cws[3] = '{8, 8, 3};
    logic [7:0] rem_o[3];
    logic [7:0] cnt_o[3];
    logic       vld_o[3];
    logic       dbn_o[3];
    assign rem_o[0] = 8'(rem5);
    assign rem_o[1] = 8'(rem7);
    assign rem_o[2] = 8'(rem2);
    assign cnt_o[0] = cnt5;
    assign cnt_o[1] = cnt7;
    assign cnt_o[2] = 8'(cnt2);
    assign vld_o[0] = vld5;
    assign vld_o[1] = vld7;
    assign vld_o[2] = vld2;
    assign dbn_o[0] = dbn5;
    assign dbn_o[1] = dbn7;
    assign dbn_o[2] = dbn2;

    int   npass = 0;
    int   ntotal = 0;
    int   bits_q[$];
    logic exp_vld = 1'b0;

    // Value of the current number mod n, from its bit list in arrival order.
    function automatic int exp_rem(int n);
        int r = 0;
        int w = 1;
        foreach (bits_q[i]) begin
`ifdef SERIAL_DIV_LSB_FIRST_EN
            r = (r + bits_q[i] * w) % n;
            w = (w * 2) % n;
`else
            r = (r * 2 + bits_q[i]) % n;
`endif
        end
        return r;
    endfunction

    function automatic int exp_cnt(int cw);
        int cap = (1 << cw) - 1;
        return (bits_q.size() > cap) ? cap : bits_q.size();
    endfunction

    task automatic step(input logic v, input logic b, input logic f, input logic r);
        new_bit_vld = v;
        new_bit = b;
        new_bit_first = f;
        rst = r;
        @(posedge clk);
        #1;
        if (r) begin
            bits_q.delete();
            exp_vld = 1'b0;
        end else if (v) begin
            if (f) bits_q.delete();
            bits_q.push_back(int'(b));
            exp_vld = 1'b1;
        end else begin
            exp_vld = 1'b0;
        end
        new_bit_vld = 1'b0;
        new_bit_first = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            ntotal++;
            if ({vld_o[i], dbn_o[i], rem_o[i], cnt_o[i]} !== {1'b0, 1'b1, 8'd0, 8'd0})
                $display("FAIL reset N=%0d vld=%0b dbn=%0b rem=%0d cnt=%0d required 0 1 0 0",
                         ns[i], vld_o[i], dbn_o[i], rem_o[i], cnt_o[i]);
            else npass++;
        end
    endtask

    task automatic test_msb_sequence;
        logic [3:0] pat = 4'b0101;
        int req5[4];
`ifdef SERIAL_DIV_LSB_FIRST_EN
        req5 = '{1, 1, 0, 0};
`else
        req5 = '{1, 2, 0, 0};
`endif
        for (int k = 0; k < 4; k++) begin
            step(1'b1, pat[k], k == 0, 1'b0);
            ntotal++;
            if ({vld5, dbn5, 8'(rem5), cnt5} !== {1'b1, req5[k] == 0, 8'(req5[k]), 8'(k + 1)})
                $display("FAIL seq1010 bit%0d vld=%0b dbn=%0b rem=%0d cnt=%0d required rem=%0d cnt=%0d",
                         k, vld5, dbn5, rem5, cnt5, req5[k], k + 1);
            else npass++;
        end
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        ntotal++;
        if ({dbn7, rem7} !== {1'b1, 3'd0})
            $display("FAIL seven_mod7 dbn=%0b rem=%0d required 1 0", dbn7, rem7);
        else npass++;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        ntotal++;
        if ({rem7, cnt7} !== {3'd1, 8'd1})
            $display("FAIL first_restart rem=%0d cnt=%0d required 1 1", rem7, cnt7);
        else npass++;
    endtask

    task automatic test_gap;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b0, g == 1, 1'b0);
            ntotal++;
            if ({vld5, rem5, cnt5} !== {1'b0, 3'd3, 8'd2})
                $display("FAIL gap_hold cyc%0d vld=%0b rem=%0d cnt=%0d required 0 3 2", g, vld5, rem5, cnt5);
            else npass++;
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        ntotal++;
        if ({vld5, rem5, cnt5} !== {1'b1, 3'd2, 8'd3})
            $display("FAIL gap_resume vld=%0b rem=%0d cnt=%0d required 1 2 3", vld5, rem5, cnt5);
        else npass++;
    endtask

    task automatic test_reset_mid_number;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        ntotal++;
        if ({vld5, dbn5, rem5, cnt5} !== {1'b0, 1'b1, 3'd0, 8'd0})
            $display("FAIL reset_mid vld=%0b dbn=%0b rem=%0d cnt=%0d required 0 1 0 0", vld5, dbn5, rem5, cnt5);
        else npass++;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        ntotal++;
        if ({vld5, rem5, cnt5} !== {1'b1, 3'd1, 8'd1})
            $display("FAIL after_reset vld=%0b rem=%0d cnt=%0d required 1 1 1", vld5, rem5, cnt5);
        else npass++;
    endtask

    task automatic test_saturation;
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, k == 0, 1'b0);
        ntotal++;
        if ({dbn2, cnt2} !== {1'b1, 3'd7})
            $display("FAIL sat_n2 dbn=%0b cnt=%0d required 1 7", dbn2, cnt2);
        else npass++;
        for (int k = 0; k < 262; k++) begin
            step(1'b1, 1'($urandom_range(0, 1)), k == 0, 1'b0);
            if (k % 37 == 0 || k > 252) begin
                for (int i = 0; i < 3; i++) begin
                    ntotal++;
                    if ({vld_o[i], dbn_o[i], rem_o[i], cnt_o[i]} !==
                        {1'b1, exp_rem(ns[i]) == 0, 8'(exp_rem(ns[i])), 8'(exp_cnt(cws[i]))})
                        $display("FAIL sat_long N=%0d k=%0d dbn=%0b rem=%0d cnt=%0d required rem=%0d cnt=%0d",
                                 ns[i], k, dbn_o[i], rem_o[i], cnt_o[i], exp_rem(ns[i]), exp_cnt(cws[i]));
                    else npass++;
                end
            end
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 99) < 2);
            for (int i = 0; i < 3; i++) begin
                ntotal++;
                if ({vld_o[i], dbn_o[i], rem_o[i], cnt_o[i]} !==
                    {exp_vld, exp_rem(ns[i]) == 0, 8'(exp_rem(ns[i])), 8'(exp_cnt(cws[i]))})
                    $display("FAIL random N=%0d k=%0d vld=%0b dbn=%0b rem=%0d cnt=%0d required vld=%0b rem=%0d cnt=%0d",
                             ns[i], k, vld_o[i], dbn_o[i], rem_o[i], cnt_o[i],
                             exp_vld, exp_rem(ns[i]), exp_cnt(cws[i]));
                else npass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb_sequence();
        test_gap();
        test_reset_mid_number();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/serial_divisibility_by_n.md
# serial_divisibility_by_n

Parametrised serial divisibility checker: accepts a binary number one bit per valid cycle and continuously reports whether the number received so far is divisible by a compile-time divisor `DIVISOR`, together with the running remainder. It generalises the fixed divide-by-3/5 serial FSMs of the finite-state-machine exercise set. It adds:

- an arbitrary divisor;
- a per-bit valid qualifier;
- a start-of-number marker;
- a saturating bit counter;
- an optional LSB-first mode.

## Interface

Parameters:
- `DIVISOR`, default 5: divisor N. Legal range 2..255; elaboration error otherwise.
- `CNT_W`, default 8: width of the bit counter.
- Derived `RW = $clog2(DIVISOR)`: remainder width.

Ports:
- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `new_bit_vld`  input  1  `new_bit` is valid this cycle; the bit is accepted at the next rising edge.
- `new_bit`  input  1  next bit of the number. Ignored when `new_bit_vld`=0.
- `new_bit_first`  input  1  qualified by `new_bit_vld`. This bit starts a new number; the old remainder is discarded. Ignored when `new_bit_vld`=0.
- `div_vld`  output  1  one-cycle pulse: outputs updated by a bit accepted at the previous edge.
- `div_by_n`  output  1  the current number mod N == 0.
- `remainder`  output  RW  the current number mod N.
- `bit_count`  output  CNT_W  bits in the current number, saturating at 2^CNT_W−1.

## Operation

- State register `st`, two states:
  - IDLE: no bit accepted since reset.
  - ACTIVE: at least one bit accepted.
- Transitions:
  - IDLE→ACTIVE on any accepted bit.
  - ACTIVE stays ACTIVE.
  - Any state→IDLE only on `rst`.
- Internal registers:
  - remainder R, RW bits.
  - weight W, RW bits (used only in LSB-first mode).
  - counter C.
- Bit acceptance: `new_bit_vld`=1 at a rising edge with `rst`=0.
- Base for the update:
  - R0=0, W0=1, C0=0 if `new_bit_first`=1 or st=IDLE.
  - Otherwise R0=R, W0=W, C0=C.
- MSB-first update (default mode):
  - t = 2·R0 + b, computed in RW+1 bits.
  - R ← t−N if t ≥ N, else t. A single conditional subtract suffices because t ≤ 2N−1.
- LSB-first update (see Configuration):
  - R ← (R0 + b·W0) mod N. Single conditional subtract, computed in RW+1 bits.
  - W ← (2·W0) mod N, single conditional subtract. For N a power of two, W reaches 0 and remains 0.
- Counter update: C ← C0+1, saturating at 2^CNT_W−1.
- Outputs:
  - `remainder`=R, `bit_count`=C, `div_by_n`=(R==0), all registered.
  - `div_vld` is registered and equals the acceptance condition of the previous edge.
- No bit accepted: R, W, C and st all hold; `div_vld`=0.
- Empty number is treated as 0: after reset `div_by_n`=1.

## Timing

- Latency: a bit accepted at edge k is reflected in all outputs immediately after edge k, with `div_vld`=1 for exactly that cycle.
- Throughput: one bit per cycle; no backpressure; back-to-back valids allowed.
- Reset values: `div_vld`=0, `div_by_n`=1, `remainder`=0, `bit_count`=0, W=1, st=IDLE.
- `rst` has priority over `new_bit_vld` in the same cycle; the bit is dropped.
- Reset mid-number discards all state. The next accepted bit starts a new number whether or not `new_bit_first` is set.
- `new_bit_first`=1 with `new_bit_vld`=0: no effect.
- Counter saturation does not affect R or W.

## Configuration

- Macro: `SERIAL_DIV_LSB_FIRST_EN`.
- Defined: the bit stream is LSB first; the W register and weighted update are compiled in.
- Undefined: the bit stream is MSB first; W is not instantiated.
- Output timing is identical in both modes.

## Test plan

- Case 1, N=5, MSB-first, bits 1,0,1,0 on consecutive cycles:
  - `remainder` 1,2,0,0.
  - `div_by_n` 0,0,1,1.
  - `bit_count` 1..4.
  - `div_vld` high four cycles.
- Case 2, N=5, bits 1,1 then a 3-cycle valid gap then bit 1: outputs hold `remainder`=3 during the gap with `div_vld`=0; then `remainder`=2 (binary 111 = 7).
- Case 3, N=7, bits 1,1,1 (7), then `new_bit_first` with bit 1: `div_by_n`=1 after the third bit; then `remainder`=1, `bit_count`=1.
- Case 4, N=5, bits 1,1 then `rst` asserted with `new_bit_vld`=1: `remainder`=0, `div_by_n`=1, `bit_count`=0, `div_vld`=0. The next bit 1 gives `remainder`=1.
- Case 5, LSB-first build:
  - N=3, bits 1,1: `remainder` 1,0.
  - N=3, bits 0,1: `remainder` 0,2.
  - N=8, bits 0,0,0,1: `remainder` stays 0, `div_by_n`=1.
- Case 6, CNT_W=3, N=2, ten bits all 0: `bit_count` saturates at 7 and `div_by_n` stays 1.
